// File: rtl/algo_1r2m_m30_wr_ingress.sv
// Write ingress stage for the 1R2M malloc-write memory.
// Each lane buffers write data, issues it to memory and returns allocated addresses.
module algo_1r2m_m30_wr_ingress #(
  parameter int NUMWRPT   = 2,
  parameter int WIDTH     = 32,
  parameter int BITADDR   = 13,
  parameter int FIFODEPTH = 4,
  parameter int BITFIFO   = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ready,
  input  logic [NUMWRPT-1:0]               in_vld,
  output logic [NUMWRPT-1:0]               in_rdy,
  input  logic [NUMWRPT*WIDTH-1:0]         in_din,
  output logic [NUMWRPT-1:0]               ma_write,
  output logic [NUMWRPT*WIDTH-1:0]         ma_din,
  input  logic [NUMWRPT*BITADDR-1:0]       ma_adr,
  input  logic [NUMWRPT-1:0]               ma_bp,
  output logic [NUMWRPT-1:0]               adr_vld,
  input  logic [NUMWRPT-1:0]               adr_rdy,
  output logic [NUMWRPT*BITADDR-1:0]       adr_out,
  output logic [NUMWRPT*(BITFIFO+1)-1:0]   dcnt,
  output logic [NUMWRPT*(BITFIFO+1)-1:0]   acnt
);

  localparam int CW = BITFIFO + 1;
  localparam logic [CW-1:0]      FULL = CW'(FIFODEPTH);
  localparam logic [CW-1:0]      CONE = CW'(1);
  localparam logic [BITFIFO-1:0] PONE = BITFIFO'(1);

  // Holds in_rdy low until the first edge after reset release
  logic alive;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) alive <= 1'b0;
    else      alive <= 1'b1;
  end

  for (genvar p = 0; p < NUMWRPT; p++) begin : g_lane
    logic [WIDTH-1:0]   dmem [FIFODEPTH];
    logic [BITADDR-1:0] amem [FIFODEPTH];
    logic [BITFIFO-1:0] dwp, drp, awp, arp;
    logic [CW-1:0]      dc, ac;
    logic               rdy, push, issue, avld, apop;
    logic [WIDTH-1:0]   din;
    logic [BITADDR-1:0] adr;

    assign din   = in_din[p*WIDTH +: WIDTH];
    assign adr   = ma_adr[p*BITADDR +: BITADDR];
    assign rdy   = alive & (dc < FULL);
    assign push  = in_vld[p] & rdy;
    assign issue = ready & ~ma_bp[p] & (dc != '0) & (ac < FULL);
    assign avld  = (ac != '0);
    assign apop  = avld & adr_rdy[p];

    assign in_rdy[p]   = rdy;
    assign ma_write[p] = issue;
    assign adr_vld[p]  = avld;
    assign ma_din[p*WIDTH +: WIDTH] =
      issue ? dmem[drp] : '0;
    assign adr_out[p*BITADDR +: BITADDR] =
      avld ? amem[arp] : '0;
    assign dcnt[p*CW +: CW] = dc;
    assign acnt[p*CW +: CW] = ac;

    // Storage needs no reset; pointers and counts define validity
    always_ff @(posedge clk) begin
      if (push)  dmem[dwp] <= din;
      if (issue) amem[awp] <= adr;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        dwp <= '0;
        drp <= '0;
        dc  <= '0;
      end else begin
        if (push)  dwp <= dwp + PONE;
        if (issue) drp <= drp + PONE;
        case ({push, issue})
          2'b10:   dc <= dc + CONE;
          2'b01:   dc <= dc - CONE;
          default: dc <= dc;
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        awp <= '0;
        arp <= '0;
        ac  <= '0;
      end else begin
        if (issue) awp <= awp + PONE;
        if (apop)  arp <= arp + PONE;
        case ({issue, apop})
          2'b10:   ac <= ac + CONE;
          2'b01:   ac <= ac - CONE;
          default: ac <= ac;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_algo_1r2m_m30_wr_ingress.sv
// Directed bench for the write ingress stage.
// Scoreboard queues track per-lane data and returned addresses.
module tb_algo_1r2m_m30_wr_ingress;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ready = 1'b0;
  logic [1:0]  in_vld = '0;
  logic [63:0] in_din = '0;
  logic [1:0]  ma_bp = '0;
  logic [1:0]  adr_rdy = '0;
  logic [25:0] ma_adr;
  logic [1:0]  in_rdy, ma_write, adr_vld;
  logic [63:0] ma_din;
  logic [25:0] adr_out;
  logic [5:0]  dcnt, acnt;

  int checks = 0;
  int failures = 0;

  logic        alive = 1'b0;
  logic [12:0] adr_drv [2];
  logic [1:0]  issued = '0;

  logic [31:0] dq0 [$];
  logic [31:0] dq1 [$];
  logic [12:0] aq0 [$];
  logic [12:0] aq1 [$];

  logic [1:0]  s_rdy, s_w, s_av;
  logic [63:0] s_din;
  logic [25:0] s_aout;
  logic [5:0]  s_dcnt, s_acnt;

  assign ma_adr = {adr_drv[1], adr_drv[0]};

  algo_1r2m_m30_wr_ingress dut (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in_din   (in_din),
    .ma_write (ma_write),
    .ma_din   (ma_din),
    .ma_adr   (ma_adr),
    .ma_bp    (ma_bp),
    .adr_vld  (adr_vld),
    .adr_rdy  (adr_rdy),
    .adr_out  (adr_out),
    .dcnt     (dcnt),
    .acnt     (acnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic lane(input int p);
    int          ds, as_;
    logic [31:0] dh;
    logic [12:0] ah;
    logic        er, ew;
    dh = '0;
    ah = '0;
    if (p == 0) begin
      ds = dq0.size();
      as_ = aq0.size();
      if (ds > 0) dh = dq0[0];
      if (as_ > 0) ah = aq0[0];
    end else begin
      ds = dq1.size();
      as_ = aq1.size();
      if (ds > 0) dh = dq1[0];
      if (as_ > 0) ah = aq1[0];
    end
    er = alive && (ds < 4);
    ew = ready && !ma_bp[p] && (ds > 0) && (as_ < 4);
    chk($sformatf("dcnt%0d", p), 64'(dcnt[p*3 +: 3]), 64'(ds));
    chk($sformatf("acnt%0d", p), 64'(acnt[p*3 +: 3]), 64'(as_));
    chk($sformatf("in_rdy%0d", p), 64'(in_rdy[p]), 64'(er));
    chk($sformatf("ma_write%0d", p), 64'(ma_write[p]), 64'(ew));
    chk($sformatf("ma_din%0d", p),
        64'(ma_din[p*32 +: 32]), ew ? 64'(dh) : 64'd0);
    chk($sformatf("adr_vld%0d", p), 64'(adr_vld[p]), 64'(as_ > 0));
    chk($sformatf("adr_out%0d", p),
        64'(adr_out[p*13 +: 13]), 64'(ah));
    if (as_ > 0 && adr_rdy[p]) begin
      if (p == 0) void'(aq0.pop_front());
      else        void'(aq1.pop_front());
    end
    if (ew) begin
      if (p == 0) begin
        void'(dq0.pop_front());
        aq0.push_back(adr_drv[0]);
      end else begin
        void'(dq1.pop_front());
        aq1.push_back(adr_drv[1]);
      end
      issued[p] = 1'b1;
    end
    if (in_vld[p] && er) begin
      if (p == 0) dq0.push_back(in_din[31:0]);
      else        dq1.push_back(in_din[63:32]);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    s_rdy = in_rdy;
    s_w = ma_write;
    s_av = adr_vld;
    s_din = ma_din;
    s_aout = adr_out;
    s_dcnt = dcnt;
    s_acnt = acnt;
    issued = '0;
    lane(0);
    lane(1);
    @(posedge clk);
    if (rst) alive = 1'b1;
    #1;
    if (issued[0]) adr_drv[0] = adr_drv[0] + 13'd3;
    if (issued[1]) adr_drv[1] = adr_drv[1] + 13'd7;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_in_rdy"}, 64'(in_rdy), 64'd0);
    chk({tag, "_ma_write"}, 64'(ma_write), 64'd0);
    chk({tag, "_ma_din"}, ma_din, 64'd0);
    chk({tag, "_adr_vld"}, 64'(adr_vld), 64'd0);
    chk({tag, "_adr_out"}, 64'(adr_out), 64'd0);
    chk({tag, "_dcnt"}, 64'(dcnt), 64'd0);
    chk({tag, "_acnt"}, 64'(acnt), 64'd0);
  endtask

  initial begin
    adr_drv[0] = 13'h005;
    adr_drv[1] = 13'h100;
    ready = 1'b1;
    #2;
    check_zero("rst");
    @(posedge clk);
    #1;
    check_zero("rst_edge");
    rst = 1'b1;
    adr_rdy = 2'b00;
    cycle();
    chk("rdy_first", 64'(s_rdy), 64'd0);
    chk("rdy_after", 64'(in_rdy), 64'h3);

    // 1: single word latency on lane 0
    in_vld = 2'b01;
    in_din[31:0] = 32'h11;
    cycle();
    in_vld = 2'b00;
    cycle();
    chk("t1_write", 64'(s_w), 64'h1);
    chk("t1_din", 64'(s_din[31:0]), 64'h11);
    cycle();
    chk("t1_avld", 64'(s_av), 64'h1);
    chk("t1_aout", 64'(s_aout[12:0]), 64'h005);
    adr_rdy = 2'b11;
    cycle();

    // 2: back-pressure on lane 1 only
    ma_bp = 2'b10;
    for (int i = 0; i < 5; i++) begin
      in_vld = (i == 0) ? 2'b11 : 2'b10;
      in_din[31:0] = 32'h22;
      in_din[63:32] = 32'hA0 + 32'(i);
      cycle();
    end
    in_vld = 2'b00;
    cycle();
    chk("t2_rdy1", 64'(s_rdy[1]), 64'd0);
    chk("t2_dcnt1", 64'(s_dcnt[5:3]), 64'd4);
    chk("t2_nowr1", 64'(s_w[1]), 64'd0);
    ma_bp = 2'b00;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk($sformatf("t2_burst%0d", i), 64'(s_w[1]), 64'd1);
      chk($sformatf("t2_data%0d", i),
          64'(s_din[63:32]), 64'hA0 + 64'(i));
    end
    cycle();
    chk("t2_done", 64'(s_w[1]), 64'd0);
    repeat (4) cycle();

    // 3: return FIFO full blocks issue
    adr_rdy = 2'b00;
    for (int i = 0; i < 8; i++) begin
      in_vld = 2'b01;
      in_din[31:0] = 32'h30 + 32'(i);
      cycle();
    end
    in_vld = 2'b00;
    cycle();
    cycle();
    chk("t3_acnt", 64'(s_acnt[2:0]), 64'd4);
    chk("t3_block", 64'(s_w[0]), 64'd0);
    adr_rdy = 2'b01;
    cycle();
    chk("t3_popcyc", 64'(s_w[0]), 64'd0);
    adr_rdy = 2'b00;
    cycle();
    chk("t3_one", 64'(s_w[0]), 64'd1);
    cycle();
    chk("t3_stop", 64'(s_w[0]), 64'd0);
    chk("t3_full", 64'(s_acnt[2:0]), 64'd4);
    adr_rdy = 2'b11;
    repeat (12) cycle();

    // 4: both lanes with random return and back-pressure
    for (int i = 0; i < 24; i++) begin
      in_vld = 2'b11;
      in_din[31:0] = 32'h4000 + 32'(i);
      in_din[63:32] = 32'h5000 + 32'(i);
      adr_rdy = 2'($urandom_range(0, 3));
      ma_bp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      ready = ($urandom_range(0, 7) != 0);
      cycle();
    end
    in_vld = 2'b00;
    ma_bp = 2'b00;
    ready = 1'b1;
    adr_rdy = 2'b11;
    repeat (14) cycle();
    chk("t4_dcnt", 64'(s_dcnt), 64'd0);
    chk("t4_acnt", 64'(s_acnt), 64'd0);

    // 5: push and issue together with one entry
    ready = 1'b0;
    in_vld = 2'b01;
    in_din[31:0] = 32'h55;
    cycle();
    ready = 1'b1;
    in_din[31:0] = 32'h66;
    cycle();
    chk("t5_old", 64'(s_din[31:0]), 64'h55);
    chk("t5_wr", 64'(s_w[0]), 64'd1);
    in_vld = 2'b00;
    cycle();
    chk("t5_dcnt", 64'(s_dcnt[2:0]), 64'd1);
    chk("t5_new", 64'(s_din[31:0]), 64'h66);
    repeat (4) cycle();

    // 6: asynchronous reset with data and addresses pending
    adr_rdy = 2'b00;
    for (int i = 0; i < 5; i++) begin
      ready = (i < 3);
      in_vld = 2'b01;
      in_din[31:0] = 32'h70 + 32'(i);
      cycle();
    end
    in_vld = 2'b00;
    cycle();
    chk("t6_dcnt", 64'(s_dcnt[2:0]), 64'd3);
    chk("t6_acnt", 64'(s_acnt[2:0]), 64'd2);
    #2;
    ready = 1'b1;
    adr_rdy = 2'b11;
    #1;
    rst = 1'b0;
    #1;
    check_zero("t6_async");
    dq0.delete();
    dq1.delete();
    aq0.delete();
    aq1.delete();
    alive = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle();
    chk("t6_rdy_low", 64'(s_rdy), 64'd0);
    repeat (3) cycle();
    chk("t6_nowr", 64'(s_w), 64'd0);
    chk("t6_noav", 64'(s_av), 64'd0);
    chk("t6_cnt", 64'({s_dcnt, s_acnt}), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
